out_port_arbiter: RTL and testbench

- Sits between the CPU's two output load strobes (integer out, char out) and a single host-side output stream.
- Buffers each output class in its own FIFO so the host may drain slowly.
- Merges the two classes onto one valid/ready channel using round-robin arbitration.
- Asserts a stall request back to the clock controller when a FIFO is full, so CPU output writes are not lost in normal operation.

---
 rtl/out_port_arbiter_if.sv | 21 ++
 rtl/out_port_arbiter.sv | 123 ++++++++++++
 tb/tb_out_port_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/out_port_arbiter_if.sv
// CPU-side output strobes and the host-side valid/ready stream of the output port arbiter.
// The arbiter takes the slave view; the CPU/host side (or a bench) takes the master view.
interface out_port_arbiter_if;
    logic [7:0] bus_in;
    logic       iout_ld_n;
    logic       cout_ld_n;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] host_data;
    logic       host_kind;

    modport master (
        output bus_in, iout_ld_n, cout_ld_n, host_ready,
        input  host_valid, host_data, host_kind
    );

    modport slave (
        input  bus_in, iout_ld_n, cout_ld_n, host_ready,
        output host_valid, host_data, host_kind
    );
endinterface

// File: rtl/out_port_arbiter.sv
// Buffers integer and char output writes in two FIFOs and merges them round-robin
// onto one registered valid/ready host stream; stalls the CPU clock while a FIFO is full.
//
// state     | meaning
// PRIO_INT  | integer FIFO wins the next both-non-empty grant
// PRIO_CHAR | char FIFO wins the next both-non-empty grant
module out_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             out_rst,
    out_port_arbiter_if.slave port,
    output logic             stall,
    output logic             ovf_int,
    output logic             ovf_char,
    output logic [AW:0]      lvl_int,
    output logic [AW:0]      lvl_char
);
    typedef enum logic {
        PRIO_INT  = 1'b0,
        PRIO_CHAR = 1'b1
    } prio_e;

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    prio_e prio_q, prio_d;

    logic [7:0]    mem_int_q  [DEPTH];
    logic [7:0]    mem_char_q [DEPTH];
    logic [AW-1:0] wr_int_q, rd_int_q, wr_char_q, rd_char_q;
    logic [AW:0]   cnt_int_q, cnt_int_d, cnt_char_q, cnt_char_d;
    logic          ovf_int_q, ovf_int_d, ovf_char_q, ovf_char_d;
    logic          valid_q, valid_d, kind_q, kind_d;
    logic [7:0]    data_q, data_d;

    logic ne_int, ne_char, out_free, grant_char;
    logic pop_int, pop_char, push_int, push_char;

    assign ne_int   = (cnt_int_q != '0);
    assign ne_char  = (cnt_char_q != '0);
    assign out_free = !valid_q || port.host_ready;

    always_comb begin
        prio_d     = prio_q;
        valid_d    = valid_q;
        data_d     = data_q;
        kind_d     = kind_q;
        pop_int    = 1'b0;
        pop_char   = 1'b0;
        grant_char = ne_char;
        if (ne_int && ne_char) begin
            grant_char = (prio_q == PRIO_CHAR);
        end
        if (out_free) begin
            valid_d = ne_int || ne_char;
            if (ne_int || ne_char) begin
                pop_int  = !grant_char;
                pop_char = grant_char;
                data_d   = grant_char ? mem_char_q[rd_char_q] : mem_int_q[rd_int_q];
                kind_d   = grant_char;
            end
            // The pointer only moves on a contested grant.
            if (ne_int && ne_char) begin
                prio_d = (prio_q == PRIO_INT) ? PRIO_CHAR : PRIO_INT;
            end
        end
    end

    // A full FIFO still accepts a push when its head leaves on the same edge.
    always_comb begin
        push_int   = !port.iout_ld_n && ((cnt_int_q != FULL) || pop_int);
        push_char  = !port.cout_ld_n && ((cnt_char_q != FULL) || pop_char);
        ovf_int_d  = ovf_int_q  || (!port.iout_ld_n && !push_int);
        ovf_char_d = ovf_char_q || (!port.cout_ld_n && !push_char);
        cnt_int_d  = cnt_int_q  + (AW + 1)'(push_int)  - (AW + 1)'(pop_int);
        cnt_char_d = cnt_char_q + (AW + 1)'(push_char) - (AW + 1)'(pop_char);
    end

    always_ff @(posedge clk or posedge out_rst) begin
        if (out_rst) begin
            prio_q     <= PRIO_INT;
            wr_int_q   <= '0;
            rd_int_q   <= '0;
            wr_char_q  <= '0;
            rd_char_q  <= '0;
            cnt_int_q  <= '0;
            cnt_char_q <= '0;
            ovf_int_q  <= 1'b0;
            ovf_char_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            kind_q     <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            cnt_int_q  <= cnt_int_d;
            cnt_char_q <= cnt_char_d;
            ovf_int_q  <= ovf_int_d;
            ovf_char_q <= ovf_char_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            kind_q     <= kind_d;
            if (push_int)  wr_int_q  <= wr_int_q + AW'(1);
            if (pop_int)   rd_int_q  <= rd_int_q + AW'(1);
            if (push_char) wr_char_q <= wr_char_q + AW'(1);
            if (pop_char)  rd_char_q <= rd_char_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_int)  mem_int_q[wr_int_q]   <= port.bus_in;
        if (push_char) mem_char_q[wr_char_q] <= port.bus_in;
    end

    assign port.host_valid = valid_q;
    assign port.host_data  = data_q;
    assign port.host_kind  = kind_q;
    assign stall           = (cnt_int_q == FULL) || (cnt_char_q == FULL);
    assign ovf_int         = ovf_int_q;
    assign ovf_char        = ovf_char_q;
    assign lvl_int         = cnt_int_q;
    assign lvl_char        = cnt_char_q;
endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: hand-computed expectations checked with
// immediate assertions one step at a time.
module tb_out_port_arbiter;
    logic       clk = 1'b0;
    logic       out_rst;
    logic       stall, ovf_int, ovf_char;
    logic [2:0] lvl_int, lvl_char;
    int         n_cmp = 0;
    int         n_err = 0;

    out_port_arbiter_if bus_if ();

    out_port_arbiter #(.DEPTH(4), .AW(2)) dut (
        .clk      (clk),
        .out_rst  (out_rst),
        .port     (bus_if.slave),
        .stall    (stall),
        .ovf_int  (ovf_int),
        .ovf_char (ovf_char),
        .lvl_int  (lvl_int),
        .lvl_char (lvl_char)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic k, input logic [7:0] d);
        chk({tag, "_valid"}, 32'(bus_if.host_valid), 32'(v));
        chk({tag, "_kind"},  32'(bus_if.host_kind),  32'(k));
        chk({tag, "_data"},  32'(bus_if.host_data),  32'(d));
    endtask

    task automatic pulse_reset();
        out_rst = 1'b1;
        #1;
        out_rst = 1'b0;
    endtask

    initial begin
        out_rst          = 1'b1;
        bus_if.bus_in    = 8'h00;
        bus_if.iout_ld_n = 1'b1;
        bus_if.cout_ld_n = 1'b1;
        bus_if.host_ready = 1'b0;
        #12;
        chk_out("rst", 1'b0, 1'b0, 8'h00);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ovf",   32'({ovf_int, ovf_char}), 32'd0);
        chk("rst_lvl",   32'({lvl_int, lvl_char}), 32'd0);
        out_rst = 1'b0;

        // Single integer write
        bus_if.iout_ld_n = 1'b0; bus_if.bus_in = 8'd42; bus_if.host_ready = 1'b1;
        tick();
        chk("s1_lvl_e1", 32'(lvl_int), 32'd1);
        chk("s1_nobypass", 32'(bus_if.host_valid), 32'd0);
        bus_if.iout_ld_n = 1'b1;
        tick();
        chk_out("s1_e2", 1'b1, 1'b0, 8'd42);
        chk("s1_lvl_e2", 32'(lvl_int), 32'd0);
        tick();
        chk("s1_e3_valid", 32'(bus_if.host_valid), 32'd0);

        // Simultaneous strobes, priority at reset is integer
        bus_if.iout_ld_n = 1'b0; bus_if.cout_ld_n = 1'b0; bus_if.bus_in = 8'h41;
        tick();
        chk("s2_lvls", 32'({lvl_int, lvl_char}), 32'({3'd1, 3'd1}));
        bus_if.iout_ld_n = 1'b1; bus_if.cout_ld_n = 1'b1;
        tick();
        chk_out("s2_e2", 1'b1, 1'b0, 8'h41);
        tick();
        chk_out("s2_e3", 1'b1, 1'b1, 8'h41);
        tick();
        chk("s2_e4_valid", 32'(bus_if.host_valid), 32'd0);

        // Drain with alternation from a fresh priority
        pulse_reset();
        bus_if.host_ready = 1'b0;
        bus_if.iout_ld_n = 1'b0; bus_if.cout_ld_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_if.bus_in = 8'h10 + 8'(i);
            tick();
        end
        bus_if.iout_ld_n = 1'b1; bus_if.cout_ld_n = 1'b1;
        chk_out("s4_hold", 1'b1, 1'b0, 8'h10);
        chk("s4_lvls", 32'({lvl_int, lvl_char}), 32'({3'd2, 3'd3}));
        bus_if.host_ready = 1'b1;
        tick(); chk_out("s4_c0", 1'b1, 1'b1, 8'h10);
        tick(); chk_out("s4_i1", 1'b1, 1'b0, 8'h11);
        tick(); chk_out("s4_c1", 1'b1, 1'b1, 8'h11);
        tick(); chk_out("s4_i2", 1'b1, 1'b0, 8'h12);
        tick(); chk_out("s4_c2", 1'b1, 1'b1, 8'h12);
        tick(); chk("s4_empty", 32'(bus_if.host_valid), 32'd0);

        // Fill char FIFO with the host stalled
        bus_if.host_ready = 1'b0;
        bus_if.cout_ld_n = 1'b0;
        bus_if.bus_in = 8'h61; tick();
        chk("s3_e1_lvl", 32'(lvl_char), 32'd1);
        bus_if.bus_in = 8'h62; tick();
        chk_out("s3_e2", 1'b1, 1'b1, 8'h61);
        bus_if.bus_in = 8'h63; tick();
        bus_if.bus_in = 8'h64; tick();
        chk("s3_e4_stall", 32'(stall), 32'd0);
        bus_if.bus_in = 8'h65; tick();
        chk("s3_e5_lvl", 32'(lvl_char), 32'd4);
        chk("s3_e5_stall", 32'(stall), 32'd1);
        chk("s3_e5_ovf", 32'(ovf_char), 32'd0);
        bus_if.bus_in = 8'h66; tick();
        chk("s3_e6_ovf", 32'(ovf_char), 32'd1);
        chk("s3_e6_lvl", 32'(lvl_char), 32'd4);
        chk("s3_e6_ovfint", 32'(ovf_int), 32'd0);
        chk_out("s3_e6", 1'b1, 1'b1, 8'h61);
        bus_if.cout_ld_n = 1'b1;
        tick();
        chk("s3_sticky", 32'(ovf_char), 32'd1);

        // Reset mid-operation: FIFO full, output valid
        out_rst = 1'b1;
        #1;
        chk("s6_valid", 32'(bus_if.host_valid), 32'd0);
        chk("s6_lvl",   32'({lvl_int, lvl_char}), 32'd0);
        chk("s6_ovf",   32'({ovf_int, ovf_char}), 32'd0);
        chk("s6_stall", 32'(stall), 32'd0);
        out_rst = 1'b0;
        tick();
        bus_if.iout_ld_n = 1'b0; bus_if.bus_in = 8'd42; bus_if.host_ready = 1'b1;
        tick();
        chk("s6_w_nobypass", 32'(bus_if.host_valid), 32'd0);
        bus_if.iout_ld_n = 1'b1;
        tick();
        chk_out("s6_w_e2", 1'b1, 1'b0, 8'd42);
        tick();
        chk("s6_w_e3_valid", 32'(bus_if.host_valid), 32'd0);

        // Full char FIFO with a pop and a push on the same edge
        bus_if.host_ready = 1'b0;
        bus_if.cout_ld_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_if.bus_in = 8'h70 + 8'(i);
            tick();
        end
        chk("s5_full_lvl", 32'(lvl_char), 32'd4);
        chk_out("s5_head", 1'b1, 1'b1, 8'h70);
        bus_if.host_ready = 1'b1;
        bus_if.bus_in = 8'h75;
        tick();
        bus_if.cout_ld_n = 1'b1;
        chk("s5_lvl", 32'(lvl_char), 32'd4);
        chk("s5_ovf", 32'(ovf_char), 32'd0);
        chk_out("s5_pop", 1'b1, 1'b1, 8'h71);
        for (int i = 2; i < 6; i++) begin
            tick();
            chk_out("s5_drain", 1'b1, 1'b1, 8'h70 + 8'(i));
        end
        tick();
        chk("s5_empty", 32'(bus_if.host_valid), 32'd0);
        chk("s5_lvl_end", 32'(lvl_char), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
